serial_comparator_ctrl: RTL and testbench

Sequencer that compares two wide unsigned operands using a single 3-bit cascadable magnitude comparator, `comparator3`. It processes one 3-bit slice per clock, LSB slice first. Each slice's lt/et/gt result is fed back as the l/e/g cascade input for the next slice. It sits between an operand-producing datapath and any consumer of a registered lt/eq/gt result, and uses a start/busy/done handshake.

---
 rtl/serial_cmp_pkg.sv | 20 ++
 rtl/serial_comparator_ctrl_comparator3.sv | 31 +++
 rtl/serial_comparator_ctrl.sv | 102 ++++++++++
 tb/tb_serial_comparator_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the slice-serial magnitude comparator.
package serial_cmp_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Cascade register layout is {l, e, g}
  typedef struct packed {
    logic l;
    logic e;
    logic g;
  } casc_t;

  localparam casc_t CASCADE_INIT = 3'b010;

endpackage

// File: rtl/serial_comparator_ctrl_comparator3.sv
// Combinational 3-bit cascadable magnitude comparator: an unequal slice
// decides, an equal slice passes the cascade input through.
module comparator3
  import serial_cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               l,
  input  logic               e,
  input  logic               g,
  output logic               lt,
  output logic               et,
  output logic               gt
);

  always_comb begin
    lt = l;
    et = e;
    gt = g;
    if (a > b) begin
      lt = 1'b0;
      et = 1'b0;
      gt = 1'b1;
    end else if (a < b) begin
      lt = 1'b1;
      et = 1'b0;
      gt = 1'b0;
    end
  end

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Compares two W-bit operands one 3-bit slice per clock, LSB slice first,
// chaining each slice's verdict into the next through a cascade register.
module serial_comparator_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int N_SLICES = 4,
  parameter int CNT_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [SLICE_W*N_SLICES-1:0] a,
  input  logic [SLICE_W*N_SLICES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic                        lt,
  output logic                        eq,
  output logic                        gt
);

  localparam int W = SLICE_W * N_SLICES;

  state_t           state, state_n;
  logic [W-1:0]     sa, sa_n, sb, sb_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  casc_t            casc, casc_n;
  logic [2:0]       res, res_n;   // {lt, eq, gt}
  logic             done_r, done_n;
  logic             c_lt, c_et, c_gt;
  logic             last;

  comparator3 u_cmp (
    .a  (sa[SLICE_W-1:0]),
    .b  (sb[SLICE_W-1:0]),
    .l  (casc.l),
    .e  (casc.e),
    .g  (casc.g),
    .lt (c_lt),
    .et (c_et),
    .gt (c_gt)
  );

  assign last = (cnt == CNT_W'(N_SLICES - 1));

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    casc_n  = casc;
    res_n   = res;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          sa_n    = a;
          sb_n    = b;
          casc_n  = CASCADE_INIT;
          cnt_n   = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        casc_n = casc_t'({c_lt, c_et, c_gt});
        sa_n   = sa >> SLICE_W;
        sb_n   = sb >> SLICE_W;
        cnt_n  = cnt + CNT_W'(1);
        if (last) begin
          res_n   = {c_lt, c_et, c_gt};
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      casc   <= CASCADE_INIT;
      res    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      sa     <= sa_n;
      sb     <= sb_n;
      cnt    <= cnt_n;
      casc   <= casc_n;
      res    <= res_n;
      done_r <= done_n;
    end
  end

  assign busy         = (state == ST_RUN);
  assign done         = done_r;
  assign {lt, eq, gt} = res;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Bench for the slice-serial comparator: a 4-slice build for handshake,
// corner and random checks, and a 1-slice build swept exhaustively.
module tb_serial_comparator_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start1 = 1'b0;
  logic [11:0] a4 = '0, b4 = '0;
  logic [2:0]  a1 = '0, b1 = '0;
  logic        busy4, done4, lt4, eq4, gt4;
  logic        busy1, done1, lt1, eq1, gt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_comparator_ctrl #(.N_SLICES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4)
  );

  serial_comparator_ctrl #(.N_SLICES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1)
  );

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  exp;  // {lt, eq, gt}
  } vec_t;

  vec_t tbl[6];

  function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full comparison on the 4-slice build with busy/done timing checks.
  task automatic do_cmp4(input logic [11:0] x, input logic [11:0] y, input logic [2:0] exp);
    @(negedge clk);
    start4 = 1'b1; a4 = x; b4 = y;
    @(posedge clk);
    #1 start4 = 1'b0;
    chk("busy_after_accept", 32'(busy4), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        chk("busy_running", 32'(busy4), 32'd1);
        chk("done_early", 32'(done4), 32'd0);
      end else begin
        chk("done_at_T0+4", 32'(done4), 32'd1);
        chk("busy_clear", 32'(busy4), 32'd0);
        chk("result", 32'({lt4, eq4, gt4}), 32'(exp));
      end
    end
  endtask

  initial begin
    tbl[0] = '{a: 12'h123, b: 12'h123, exp: 3'b010};
    tbl[1] = '{a: 12'h800, b: 12'h7FF, exp: 3'b001};
    tbl[2] = '{a: 12'h7FF, b: 12'h800, exp: 3'b100};
    tbl[3] = '{a: 12'h001, b: 12'h000, exp: 3'b001};
    tbl[4] = '{a: 12'h000, b: 12'h001, exp: 3'b100};
    tbl[5] = '{a: 12'hFFF, b: 12'hFFF, exp: 3'b010};

    #12;
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_res4", 32'({lt4, eq4, gt4}), 32'd0);
    chk("rst_res1", 32'({busy1, done1, lt1, eq1, gt1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) do_cmp4(tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 30; i++) begin
      logic [11:0] x, y;
      x = 12'($urandom);
      y = (i % 4 == 0) ? x ^ 12'(1 << $urandom_range(11, 0)) : 12'($urandom);
      do_cmp4(x, y, ref_cmp(x, y));
    end

    // start held high; operands changed mid-run must not leak in.
    @(negedge clk);
    start4 = 1'b1; a4 = 12'h000; b4 = 12'hFFF;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin a4 = 12'hFFF; b4 = 12'h000; end
      @(posedge clk);
      #1;
      chk("bb_done", 32'(done4), 32'(k == 4 || k == 9));
      chk("bb_busy", 32'(busy4), 32'(!(k == 4 || k == 9)));
      if (k == 4) chk("bb_first", 32'({lt4, eq4, gt4}), 32'b100);
      if (k == 6) chk("bb_hold", 32'({lt4, eq4, gt4}), 32'b100);
      if (k == 9) chk("bb_second", 32'({lt4, eq4, gt4}), 32'b001);
    end
    start4 = 1'b0;
    repeat (5) @(posedge clk);

    // Reset mid-operation.
    @(negedge clk);
    start4 = 1'b1; a4 = 12'h000; b4 = 12'h001;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_done", 32'(done4), 32'd0);
    chk("midrst_res", 32'({lt4, eq4, gt4}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk("midrst_nodone", 32'(done4), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_cmp4(12'hABC, 12'hABD, 3'b100);

    // Exhaustive sweep of the 1-slice build, back-to-back starts.
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        @(negedge clk);
        start1 = 1'b1; a1 = 3'(x); b1 = 3'(y);
        @(posedge clk);
        #1;
        chk("n1_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        start1 = 1'b0;
        @(posedge clk);
        #1;
        chk("n1_done", 32'(done1), 32'd1);
        chk("n1_res", 32'({lt1, eq1, gt1}), 32'(ref_cmp(x, y)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
